// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: x0 hardwired to zero, sequential clear sweep with busy, write-conflict pulse.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic [NRD*AW-1:0]   rsR_i,
    output logic [NRD*XLEN-1:0] dataR_o,
    input  logic [NWR*AW-1:0]   rsW_i,
    input  logic [NWR*XLEN-1:0] dataW_i,
    input  logic [NWR-1:0]      regWEn_i,
    output logic                busy_o,
    output logic                wr_conflict_o
);

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] FIRST = AW'(1);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic          busy;
    logic          conflict;
    logic          conflict_nxt;
    logic          wr_en;

    logic [XLEN-1:0] regs  [NREGS];
    logic [AW-1:0]   waddr [NWR];
    logic [XLEN-1:0] wdata [NWR];

    for (genvar w = 0; w < NWR; w++) begin : g_wunpack
        assign waddr[w] = rsW_i[w*AW +: AW];
        assign wdata[w] = dataW_i[w*XLEN +: XLEN];
    end

    // A clear request or reset in the same cycle takes precedence over any write.
    assign wr_en = (state == READY) && !clr_i && !rst_i;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            READY: begin
                if (clr_i) begin
                    state_nxt = CLEAR;
                    idx_nxt   = FIRST;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_nxt = READY;
                end else begin
                    idx_nxt = idx + FIRST;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= CLEAR;
            idx      <= FIRST;
            busy     <= 1'b1;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            busy     <= (state_nxt == CLEAR);
            conflict <= conflict_nxt;
        end
    end

    // Later ports are assigned last, so the highest-index writer wins a collision.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_en) begin
            for (int w = 0; w < NWR; w++) begin
                if (regWEn_i[w] && (waddr[w] != '0)) begin
                    regs[waddr[w]] <= wdata[w];
                end
            end
        end
    end

    if (NWR == 2) begin : g_conflict
        assign conflict_nxt = (state == READY) && regWEn_i[0] && regWEn_i[1] &&
                              (waddr[0] == waddr[1]) && (waddr[0] != '0);
    end else begin : g_no_conflict
        assign conflict_nxt = 1'b0;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdata;

        assign raddr = rsR_i[k*AW +: AW];

        always_comb begin
            rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
            if (state == READY) begin
                for (int w = 0; w < NWR; w++) begin
                    if (regWEn_i[w] && (waddr[w] != '0) && (waddr[w] == raddr)) begin
                        rdata = wdata[w];
                    end
                end
            end
`endif
            if ((raddr == '0) || busy) begin
                rdata = '0;
            end
        end

        assign dataR_o[k*XLEN +: XLEN] = rdata;
    end

    assign busy_o        = busy;
    assign wr_conflict_o = conflict;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. Successor to the single-write, dual-read RV32I RegFile. Generalises width, depth, read-port count and write-port count. Adds a sequential clear sweep with a busy handshake, same-cycle write-conflict detection, and optional write-to-read bypass. Sits in decode/writeback of the RV32I core; NRD=2, NWR=1 is the drop-in configuration.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >=4); register 0 hardwired to zero
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (1 or 2)
AW (localparam), $clog2(NREGS), register address width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
clr_i  input  1  request runtime clear sweep (sampled only in READY)
rsR_i  input  NRD*AW  read addresses; port k = bits [k*AW +: AW]
dataR_o  output  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
rsW_i  input  NWR*AW  write addresses, packed as rsR_i
dataW_i  input  NWR*XLEN  write data, packed as dataR_o
regWEn_i  input  NWR  per-port write enable
busy_o  output  1  registered; high while reset or clear sweep is active
wr_conflict_o  output  1  registered one-cycle pulse on a write-address collision

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Storage: register 0 always reads 0; writes to address 0 are dropped. Storage is not reset directly; the clear sweep zeroes it.
- Reads: combinational, zero latency. dataR_o[k] = 0 if rsR_i[k]==0 or busy_o==1; otherwise RegArray[rsR_i[k]].
- Writes: on a rising edge in READY, each port with regWEn_i=1 and nonzero address writes dataW_i. Data is visible on reads the following cycle (see optional feature).
- Write priority: if two ports target the same nonzero address in the same cycle, the higher port index wins.
- FSM states: READY, CLEAR. idx is an AW-bit sweep counter.
- Reset: rst_i=1 at an edge sets state=CLEAR, idx=1, busy_o=1, wr_conflict_o=0. Reset asserted mid-sweep restarts the sweep at idx=1.
- CLEAR: each edge writes RegArray[idx]=0. When idx==NREGS-1, the FSM moves to READY and busy_o is 0 from the next cycle; otherwise idx increments.
- Sweep timing: busy_o stays high exactly NREGS-1 cycles after rst_i deasserts (31 at default).
- Writes and clr_i during CLEAR are ignored; no conflict is flagged.
- READY with clr_i=1: the FSM enters CLEAR with idx=1 and busy_o=1 next cycle. The sweep takes NREGS-1 cycles.
- clr_i and write in the same cycle: clear wins and the write is dropped.
- wr_conflict_o (NWR=2 only): asserted the cycle after an edge in READY where both enables are 1 and both addresses are equal and nonzero. Otherwise 0. Tied to 0 when NWR=1.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if a write port with regWEn_i=1 targets nonzero address a, any read port with rsR_i==a returns that port's dataW_i in the same cycle. Write priority applies; the bypass uses the highest-index matching writer. There is no bypass while busy_o=1 or for address 0.
- Undefined: no forwarding; a read returns the pre-write value until the edge after the write.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then 0 -> busy_o=1 for 31 cycles then 0; all dataR_o=0; regWEn_i asserted during the sweep has no effect.
- Basic R/W: write x5=0xDEADBEEF -> next cycle rsR port0=5 reads 0xDEADBEEF; write x0=0x12345678 -> x0 still reads 0.
- Bypass: same cycle write x7=0xA5A5A5A5 while port1 reads 7 -> reads 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, previous value without it; both builds read 0xA5A5A5A5 next cycle.
- Dual write (NWR=2): port0 x9=0x1111, port1 x9=0x2222 -> x9 reads 0x2222, wr_conflict_o=1 for exactly 1 cycle; x0 on both ports -> no pulse.
- Runtime clear: fill x1..x31 with the values of their indices, pulse clr_i -> busy_o high 31 cycles; afterward every register reads 0; a write issued alongside clr_i is lost.
- Reset mid-sweep: assert rst_i at sweep cycle 10 -> busy_o stays high and falls 31 cycles after rst_i deasserts.
